// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshaking and a 2-entry skid buffer.
// o_Ready comes from the skid valid flop only, so back-pressure never crosses the stage combinationally.
module pipe_stage_skid_reg #(
   parameter int PC_W   = 32,
   parameter int CTRL_W = 3,
   parameter int DATA_W = 64,
   parameter int DEST_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_Flush,
   input  logic              i_Freeze,
   input  logic              i_Valid,
   output logic              o_Ready,
   input  logic [PC_W-1:0]   i_Pc,
   input  logic [CTRL_W-1:0] i_Ctrl,
   input  logic [DATA_W-1:0] i_Data,
   input  logic [DEST_W-1:0] i_Destination,
   output logic              o_Valid,
   input  logic              i_Ready,
   output logic [PC_W-1:0]   o_Pc,
   output logic [CTRL_W-1:0] o_Ctrl,
   output logic [DATA_W-1:0] o_Data,
   output logic [DEST_W-1:0] o_Destination,
   output logic [1:0]        o_Count
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t              state_q;
   logic [1:0]          count_q;
   logic                main_valid_q;
   logic [PC_W-1:0]     main_pc_q;
   logic [CTRL_W-1:0]   main_ctrl_q;
   logic [DATA_W-1:0]   main_data_q;
   logic [DEST_W-1:0]   main_dest_q;
   logic                skid_valid_q;
   logic [PC_W-1:0]     skid_pc_q;
   logic [CTRL_W-1:0]   skid_ctrl_q;
   logic [DATA_W-1:0]   skid_data_q;
   logic [DEST_W-1:0]   skid_dest_q;

   logic accept;
   logic drain;

   assign o_Ready       = ~skid_valid_q & ~i_Freeze;
   assign o_Valid       = main_valid_q & ~i_Freeze;
   assign accept        = i_Valid & o_Ready;
   assign drain         = o_Valid & i_Ready;

   // Control bits are gated so a bubble can never trigger write-back or memory access.
   assign o_Ctrl        = o_Valid ? main_ctrl_q : '0;
   assign o_Pc          = main_pc_q;
   assign o_Data        = main_data_q;
   assign o_Destination = main_dest_q;
   assign o_Count       = count_q;

   always_ff @(posedge clk) begin
      if (reset || i_Flush) begin
         state_q      <= S_EMPTY;
         count_q      <= 2'd0;
         main_valid_q <= 1'b0;
         main_pc_q    <= '0;
         main_ctrl_q  <= '0;
         main_data_q  <= '0;
         main_dest_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_ctrl_q  <= '0;
         skid_data_q  <= '0;
         skid_dest_q  <= '0;
      end else if (!i_Freeze) begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  main_valid_q <= 1'b1;
                  main_pc_q    <= i_Pc;
                  main_ctrl_q  <= i_Ctrl;
                  main_data_q  <= i_Data;
                  main_dest_q  <= i_Destination;
                  count_q      <= 2'd1;
                  state_q      <= S_ONE;
               end
            end
            S_ONE: begin
               if (accept && drain) begin
                  main_pc_q    <= i_Pc;
                  main_ctrl_q  <= i_Ctrl;
                  main_data_q  <= i_Data;
                  main_dest_q  <= i_Destination;
               end else if (accept) begin
                  skid_valid_q <= 1'b1;
                  skid_pc_q    <= i_Pc;
                  skid_ctrl_q  <= i_Ctrl;
                  skid_data_q  <= i_Data;
                  skid_dest_q  <= i_Destination;
                  count_q      <= 2'd2;
                  state_q      <= S_FULL;
               end else if (drain) begin
                  // Payload registers keep their last values; only the valid bit drops.
                  main_valid_q <= 1'b0;
                  count_q      <= 2'd0;
                  state_q      <= S_EMPTY;
               end
            end
            S_FULL: begin
               if (drain) begin
                  main_pc_q    <= skid_pc_q;
                  main_ctrl_q  <= skid_ctrl_q;
                  main_data_q  <= skid_data_q;
                  main_dest_q  <= skid_dest_q;
                  skid_valid_q <= 1'b0;
                  skid_pc_q    <= '0;
                  skid_ctrl_q  <= '0;
                  skid_data_q  <= '0;
                  skid_dest_q  <= '0;
                  count_q      <= 2'd1;
                  state_q      <= S_ONE;
               end
            end
            default: begin
               state_q      <= S_EMPTY;
               count_q      <= 2'd0;
               main_valid_q <= 1'b0;
               skid_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: hand-written directed sequence, a table of cycle vectors,
// then randomized traffic compared against a queue-based model of the stage.
module tb_pipe_stage_skid_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_Flush = 1'b0;
   logic        i_Freeze = 1'b0;
   logic        i_Valid = 1'b0;
   logic        o_Ready;
   logic [31:0] i_Pc = '0;
   logic [2:0]  i_Ctrl = '0;
   logic [63:0] i_Data = '0;
   logic [3:0]  i_Destination = '0;
   logic        o_Valid;
   logic        i_Ready = 1'b0;
   logic [31:0] o_Pc;
   logic [2:0]  o_Ctrl;
   logic [63:0] o_Data;
   logic [3:0]  o_Destination;
   logic [1:0]  o_Count;

   int vectors = 0;
   int miscompares = 0;

   pipe_stage_skid_reg #(.PC_W(32), .CTRL_W(3), .DATA_W(64), .DEST_W(4)) dut (
      .clk(clk), .reset(reset), .i_Flush(i_Flush), .i_Freeze(i_Freeze),
      .i_Valid(i_Valid), .o_Ready(o_Ready), .i_Pc(i_Pc), .i_Ctrl(i_Ctrl),
      .i_Data(i_Data), .i_Destination(i_Destination), .o_Valid(o_Valid),
      .i_Ready(i_Ready), .o_Pc(o_Pc), .o_Ctrl(o_Ctrl), .o_Data(o_Data),
      .o_Destination(o_Destination), .o_Count(o_Count)
   );

   always #5 clk = ~clk;

   // Table items derive their payload from the PC; every field is zero for PC 0.
   function automatic logic [63:0] fdata(logic [31:0] pc);
      return {pc, pc * 32'd3};
   endfunction
   function automatic logic [3:0] fdest(logic [31:0] pc);
      return pc[5:2] ^ pc[15:12];
   endfunction
   function automatic logic [2:0] fctrl(logic [31:0] pc);
      return pc[4:2] ^ pc[14:12];
   endfunction

   typedef struct {
      logic        rst, fl, fz, v, r;
      logic [31:0] pc;
      logic        ev, er;
      logic [1:0]  ec;
      logic [31:0] epc;
   } vec_t;

   function automatic vec_t mk(logic rst, logic fl, logic fz, logic v, logic r, logic [31:0] pc,
                               logic ev, logic er, logic [1:0] ec, logic [31:0] epc);
      vec_t t;
      t.rst = rst; t.fl = fl; t.fz = fz; t.v = v; t.r = r; t.pc = pc;
      t.ev = ev; t.er = er; t.ec = ec; t.epc = epc;
      return t;
   endfunction

   typedef struct {
      logic [31:0] pc;
      logic [2:0]  ctrl;
      logic [63:0] data;
      logic [3:0]  dest;
   } item_t;

   task automatic check(string name, logic ev, logic er, logic [1:0] ec, logic [31:0] epc,
                        logic [2:0] ectrl, logic [63:0] edata, logic [3:0] edest);
      vectors++;
      if (o_Valid !== ev || o_Ready !== er || o_Count !== ec || o_Pc !== epc ||
          o_Ctrl !== ectrl || o_Data !== edata || o_Destination !== edest) begin
         miscompares++;
         $display("FAIL %s: got v=%b rdy=%b cnt=%0d pc=%h ctrl=%b data=%h dest=%h, want v=%b rdy=%b cnt=%0d pc=%h ctrl=%b data=%h dest=%h",
                  name, o_Valid, o_Ready, o_Count, o_Pc, o_Ctrl, o_Data, o_Destination,
                  ev, er, ec, epc, ectrl, edata, edest);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t  tbl[35];
   item_t mq[$];
   item_t last_out;
   item_t head;
   item_t in_item;

   initial begin
      // Backpressure, then re-accept of the refused item
      tbl[0]  = mk(0,0,0,1,0,32'h1000, 0,1,0,32'h0);
      tbl[1]  = mk(0,0,0,1,0,32'h1004, 1,1,1,32'h1000);
      tbl[2]  = mk(0,0,0,1,0,32'h1008, 1,0,2,32'h1000);
      tbl[3]  = mk(0,0,0,1,1,32'h1008, 1,0,2,32'h1000);
      tbl[4]  = mk(0,0,0,1,1,32'h1008, 1,1,1,32'h1004);
      tbl[5]  = mk(0,0,0,0,1,32'h0,    1,1,1,32'h1008);
      tbl[6]  = mk(0,0,0,0,1,32'h0,    0,1,0,32'h1008);
      // Streaming at one item per cycle
      tbl[7]  = mk(0,0,0,1,1,32'h00,   0,1,0,32'h1008);
      for (int k = 1; k < 8; k++)
         tbl[7+k] = mk(0,0,0,1,1,32'(4*k), 1,1,1,32'(4*(k-1)));
      tbl[15] = mk(0,0,0,0,1,32'h0,    1,1,1,32'h1C);
      // Flush while full drops the held items and the offered one
      tbl[16] = mk(0,0,0,1,0,32'h1010, 0,1,0,32'h1C);
      tbl[17] = mk(0,0,0,1,0,32'h1014, 1,1,1,32'h1010);
      tbl[18] = mk(0,1,0,1,0,32'h2000, 1,0,2,32'h1010);
      tbl[19] = mk(0,0,0,0,1,32'h0,    0,1,0,32'h0);
      // Freeze holds one item; freeze+flush lets flush win
      tbl[20] = mk(0,0,0,1,0,32'h3000, 0,1,0,32'h0);
      tbl[21] = mk(0,0,1,1,1,32'h3004, 0,0,1,32'h3000);
      tbl[22] = mk(0,0,1,1,1,32'h3004, 0,0,1,32'h3000);
      tbl[23] = mk(0,0,1,1,1,32'h3004, 0,0,1,32'h3000);
      tbl[24] = mk(0,0,0,0,1,32'h0,    1,1,1,32'h3000);
      tbl[25] = mk(0,0,0,1,0,32'h3008, 0,1,0,32'h3000);
      tbl[26] = mk(0,1,1,1,1,32'h300C, 0,0,1,32'h3008);
      tbl[27] = mk(0,0,0,0,1,32'h0,    0,1,0,32'h0);
      // Reset while full, then a fresh item with latency 1
      tbl[28] = mk(0,0,0,1,0,32'h4000, 0,1,0,32'h0);
      tbl[29] = mk(0,0,0,1,1,32'h4004, 1,1,1,32'h4000);
      tbl[30] = mk(0,0,0,1,0,32'h4008, 1,1,1,32'h4004);
      tbl[31] = mk(1,0,0,1,1,32'h400C, 1,0,2,32'h4004);
      tbl[32] = mk(0,0,0,1,1,32'h4010, 0,1,0,32'h0);
      tbl[33] = mk(0,0,0,0,1,32'h0,    1,1,1,32'h4010);
      tbl[34] = mk(0,0,0,0,0,32'h0,    0,1,0,32'h4010);

      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("reset", 0, 1, 0, 32'h0, 3'b0, 64'h0, 4'h0);
      $display("directed reset: v=%b rdy=%b cnt=%0d", o_Valid, o_Ready, o_Count);

      i_Valid = 1'b1; i_Ready = 1'b1; i_Pc = 32'h1000; i_Ctrl = 3'b011;
      i_Data = 64'hABCD1234_98765432; i_Destination = 4'hA;
      tick();
      i_Valid = 1'b0;
      #1;
      check("basic", 1, 1, 1, 32'h1000, 3'b011, 64'hABCD1234_98765432, 4'hA);
      $display("directed basic: pc=%h ctrl=%b data=%h dest=%h", o_Pc, o_Ctrl, o_Data, o_Destination);
      tick();
      check("basic_drain", 0, 1, 0, 32'h1000, 3'b000, 64'hABCD1234_98765432, 4'hA);
      $display("directed drain: v=%b pc=%h", o_Valid, o_Pc);
      i_Flush = 1'b1;
      tick();
      i_Flush = 1'b0;

      for (int i = 0; i < 35; i++) begin
         reset = tbl[i].rst; i_Flush = tbl[i].fl; i_Freeze = tbl[i].fz;
         i_Valid = tbl[i].v; i_Ready = tbl[i].r;
         i_Pc = tbl[i].pc; i_Ctrl = fctrl(tbl[i].pc);
         i_Data = fdata(tbl[i].pc); i_Destination = fdest(tbl[i].pc);
         #1;
         check($sformatf("row%0d", i), tbl[i].ev, tbl[i].er, tbl[i].ec, tbl[i].epc,
               tbl[i].ev ? fctrl(tbl[i].epc) : 3'b000, fdata(tbl[i].epc), fdest(tbl[i].epc));
         $display("row %0d: in v=%b r=%b pc=%h -> out v=%b rdy=%b cnt=%0d pc=%h",
                  i, i_Valid, i_Ready, i_Pc, o_Valid, o_Ready, o_Count, o_Pc);
         @(posedge clk);
         #1;
      end

      // Randomized phase: the model is a FIFO of at most two items plus the last item handed out.
      reset = 1'b1; i_Flush = 1'b0; i_Freeze = 1'b0; i_Valid = 1'b0; i_Ready = 1'b0;
      tick();
      mq.delete();
      last_out = '{pc: '0, ctrl: '0, data: '0, dest: '0};
      begin
         int bad_before;
         bad_before = miscompares;
         for (int c = 0; c < 3000; c++) begin
            logic exp_v, exp_r;
            reset    = ($urandom_range(0, 99) == 0);
            i_Flush  = ($urandom_range(0, 39) == 0);
            i_Freeze = ($urandom_range(0, 9) == 0);
            i_Valid  = ($urandom_range(0, 3) != 0);
            i_Ready  = ($urandom_range(0, 2) != 0);
            in_item.pc   = $urandom;
            in_item.ctrl = 3'($urandom);
            in_item.data = {$urandom, $urandom};
            in_item.dest = 4'($urandom);
            i_Pc = in_item.pc; i_Ctrl = in_item.ctrl;
            i_Data = in_item.data; i_Destination = in_item.dest;
            #1;
            head  = (mq.size() > 0) ? mq[0] : last_out;
            exp_v = (mq.size() > 0) && !i_Freeze;
            exp_r = (mq.size() < 2) && !i_Freeze;
            check($sformatf("rand%0d", c), exp_v, exp_r, 2'(mq.size()), head.pc,
                  exp_v ? head.ctrl : 3'b000, head.data, head.dest);
            @(posedge clk);
            if (reset || i_Flush) begin
               mq.delete();
               last_out = '{pc: '0, ctrl: '0, data: '0, dest: '0};
            end else begin
               if (exp_v && i_Ready) last_out = mq.pop_front();
               if (i_Valid && exp_r) mq.push_back(in_item);
            end
            #1;
         end
         $display("random phase: 3000 cycles, %0d new miscompares", miscompares - bad_before);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
